stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/stream_mux_rr.sv | 95 +++++++++
 tb/tb_stream_mux_rr.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the registered round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index + 1, wrapping back to 0 after n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    int unsigned c;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant
// and a single registered output stage with backpressure.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] fix_grant;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              load_ok;
    logic              xfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Out-of-range select yields no grant at all.
    always_comb begin
        fix_grant = '0;
        if (32'(sel) < NUM_CH) begin
            if (in_valid[sel]) fix_grant[sel] = 1'b1;
        end
    end

    always_comb begin
        grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
        grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
        load_ok   = ~out_valid_q | out_ready;
        in_ready  = grant & {NUM_CH{load_ok}};
        xfer      = |in_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            out_ch_d    = grant_idx;
            if (mode == MODE_RR) rr_ptr_d = SEL_W'(wrap_inc(int'(grant_idx), NUM_CH));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main paths
// and a 3-channel instance to reach an out-of-range select value.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4-channel, 32-bit instance
    logic         a_mode, a_out_ready, a_out_valid;
    logic [1:0]   a_sel, a_out_ch;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [127:0] a_in_data;
    logic [31:0]  a_out_data;

    // 3-channel, 8-bit instance
    logic         b_mode, b_out_ready, b_out_valid;
    logic [1:0]   b_sel, b_out_ch;
    logic [2:0]   b_in_valid, b_in_ready;
    logic [23:0]  b_in_data;
    logic [7:0]   b_out_data;

    stream_mux_rr #(.WIDTH(32), .NUM_CH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
        .out_ready(a_out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .NUM_CH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_ready(b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({a_out_valid, a_out_data, a_out_ch, a_in_ready} !== 39'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h ch=%0d rdy=%b, want all 0",
                     a_out_valid, a_out_data, a_out_ch, a_in_ready);
        end
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
        // load ch2 in RR mode so rr_ptr moves to 3, then reset mid-cycle
        a_mode = 1'b1; a_out_ready = 1'b0;
        a_in_valid = 4'b0100;
        a_in_data = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
        tick();
        a_in_valid = 4'b0000;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hD0000002) begin
            errors++;
            $display("FAIL reset_preload: got v=%b d=%h, want v=1 d=d0000002", a_out_valid, a_out_data);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%h ch=%0d, want 0 0 0", a_out_valid, a_out_data, a_out_ch);
        end
        #1 rst_n = 1'b1;
        a_in_valid = 4'b1111;
        #1;
        checks++;
        if (a_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_rr_first: got in_ready=%b, want 0001", a_in_ready);
        end
        a_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fixed();
        a_mode = 1'b0; a_sel = 2'd2; a_out_ready = 1'b1;
        a_in_data = {32'h0, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        a_in_valid = 4'b0111;
        #1;
        checks++;
        if (a_in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready: got %b, want 0100", a_in_ready);
        end
        tick();
        a_in_valid = 4'b0000;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hCAFE0002 || a_out_ch !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out: got v=%b d=%h ch=%0d, want 1 cafe0002 2",
                     a_out_valid, a_out_data, a_out_ch);
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'hCAFE0002) begin
            errors++;
            $display("FAIL fixed_drain: got v=%b d=%h, want 0 cafe0002", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_rr_sequence();
        logic [31:0] exp_d;
        a_mode = 1'b1; a_out_ready = 1'b1;
        a_in_data = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
        a_in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_d = 32'hD0000000 + 32'(i % 4);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_ch !== 2'(i % 4) || a_out_data !== exp_d) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h, want 1 %0d %h",
                         i, a_out_valid, a_out_ch, a_out_data, i % 4, exp_d);
            end
        end
        a_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr_wrap();
        a_mode = 1'b1; a_out_ready = 1'b1;
        a_in_valid = 4'b0100;
        tick();
        a_in_valid = 4'b0010;
        #1;
        checks++;
        if (a_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rr_wrap_ch1: got %b, want 0010", a_in_ready);
        end
        tick();
        checks++;
        if (a_out_ch !== 2'd1 || a_out_data !== 32'hD0000001) begin
            errors++;
            $display("FAIL rr_wrap_out1: got ch=%0d d=%h, want 1 d0000001", a_out_ch, a_out_data);
        end
        a_in_valid = 4'b0101;
        #1;
        checks++;
        if (a_in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rr_wrap_ch2_first: got %b, want 0100", a_in_ready);
        end
        tick();
        checks++;
        if (a_out_ch !== 2'd2 || a_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap_then_ch0: got ch=%0d rdy=%b, want 2 0001", a_out_ch, a_in_ready);
        end
        tick();
        a_in_valid = 4'b0000;
        checks++;
        if (a_out_ch !== 2'd0 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_wrap_out0: got ch=%0d v=%b, want 0 1", a_out_ch, a_out_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        a_mode = 1'b1; a_out_ready = 1'b0;
        a_in_data = {96'h0, 32'hB0B00000};
        a_in_valid = 4'b0001;
        tick();
        a_in_data = {96'h0, 32'hB0B00001};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b1 || a_out_data !== 32'hB0B00000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h, want 0000 1 b0b00000",
                         i, a_in_ready, a_out_valid, a_out_data);
            end
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 0001", a_in_ready);
        end
        tick();
        a_in_valid = 4'b0000;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hB0B00001) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b d=%h, want 1 b0b00001", a_out_valid, a_out_data);
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_sel_out_of_range();
        b_mode = 1'b0; b_sel = 2'd3; b_out_ready = 1'b1;
        b_in_data = {8'hA2, 8'hA1, 8'hA0};
        b_in_valid = 3'b111;
        #1;
        checks++;
        if (b_in_ready !== 3'b000) begin
            errors++;
            $display("FAIL sel_oob_ready: got %b, want 000", b_in_ready);
        end
        tick(); tick();
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_oob_valid: got %b, want 0", b_out_valid);
        end
        b_mode = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 3'b001) begin
            errors++;
            $display("FAIL sel_oob_rr_ready: got %b, want 001", b_in_ready);
        end
        tick();
        b_in_valid = 3'b000;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_ch !== 2'd0 || b_out_data !== 8'hA0) begin
            errors++;
            $display("FAIL sel_oob_rr_out: got v=%b ch=%0d d=%h, want 1 0 a0",
                     b_out_valid, b_out_ch, b_out_data);
        end
    endtask

    initial begin
        a_mode = 1'b0; a_sel = '0; a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b0;
        b_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b0;
        #1;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_rr_wrap();
        test_backpressure();
        test_sel_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
